irq_controller: RTL and testbench

Machine-mode interrupt sequencer that sits between external interrupt request lines and the CSR file / PC mux. Each cycle it masks the level-sensitive requests with `mie` and picks the lowest-index winner. At an instruction boundary it issues a one-cycle trap strobe that loads `mepc`/`mcause` and redirects the PC to `mtvec`. It then holds off further traps until `mret` and acknowledges the serviced source on return. There is no nesting: one handler is active at a time.

---
 rtl/irq_controller_if.sv | 34 +++
 rtl/irq_controller.sv | 87 ++++++++
 tb/tb_irq_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// Interrupt controller bus: request/enable/handshake inputs toward the
// controller and trap/cause/acknowledge outputs back to the core and devices.
//   irq_req_i        level requests, bit i held by device i until acknowledged
//   mie_i            mie CSR value, bit 16+i enables irq_req_i[i]
//   instr_boundary_i core can accept a trap this cycle
//   mret_i           mret retires this cycle
//   trap_o           one-cycle trap strobe (CSR update + mtvec redirect)
//   mcause_o         cause value, 32'h8000_0010 + winner index
//   irq_ret_o        one-hot acknowledge pulse to the serviced device
//   busy_o           handler in progress
interface irq_controller_if #(
  parameter int unsigned N_IRQ = 16
);
  logic [N_IRQ-1:0] irq_req_i;
  logic [31:0]      mie_i;
  logic             instr_boundary_i;
  logic             mret_i;
  logic             trap_o;
  logic [31:0]      mcause_o;
  logic [N_IRQ-1:0] irq_ret_o;
  logic             busy_o;

  // Controller side
  modport slave (
    input  irq_req_i, mie_i, instr_boundary_i, mret_i,
    output trap_o, mcause_o, irq_ret_o, busy_o
  );

  // Core/device side
  modport master (
    output irq_req_i, mie_i, instr_boundary_i, mret_i,
    input  trap_o, mcause_o, irq_ret_o, busy_o
  );
endinterface

// File: rtl/irq_controller.sv
// Machine-mode interrupt sequencer. Masks level requests with mie, selects
// the lowest-index pending source, raises a one-cycle trap at an instruction
// boundary, holds off further traps until mret, then acknowledges the
// serviced source with a one-cycle one-hot pulse. No nesting.
// Ports:
//   clk_i  clock, all state on rising edge
//   rst_i  synchronous active-high reset
//   bus    irq_controller_if slave modport (requests, mie, boundary, mret in;
//          trap, mcause, irq_ret, busy out)
module irq_controller #(
  parameter int unsigned N_IRQ = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  irq_controller_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRAP    = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RETURN  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cur_idx_q, cur_idx_d;
  logic [31:0]      mcause_q, mcause_d;

  logic [N_IRQ-1:0] pending;
  logic [3:0]       winner;
  logic             found;
  logic             unused_mie;

  // Only mie[16 +: N_IRQ] carries meaning here.
  assign unused_mie = ^bus.mie_i;

  // Lowest set index wins.
  always_comb begin
    pending = bus.irq_req_i & bus.mie_i[16 +: N_IRQ];
    winner  = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (!found && pending[i]) begin
        winner = 4'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    mcause_d  = mcause_q;
    case (state_q)
      ST_IDLE: begin
        if (found && bus.instr_boundary_i) begin
          cur_idx_d = winner;
          mcause_d  = 32'h8000_0010 + {28'b0, winner};
          state_d   = ST_TRAP;
        end
      end
      ST_TRAP:    state_d = ST_SERVICE;
      ST_SERVICE: if (bus.mret_i) state_d = ST_RETURN;
      ST_RETURN:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cur_idx_q <= '0;
      mcause_q  <= '0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      mcause_q  <= mcause_d;
    end
  end

  // Outputs decode registered state only.
  assign bus.trap_o    = (state_q == ST_TRAP);
  assign bus.busy_o    = (state_q == ST_TRAP) || (state_q == ST_SERVICE);
  assign bus.mcause_o  = mcause_q;
  assign bus.irq_ret_o = (state_q == ST_RETURN) ? (N_IRQ'(1) << cur_idx_q) : '0;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios followed by a
// randomized run, all compared against a behavioural handler model.
module tb_irq_controller;

  localparam int unsigned N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_controller_if #(.N_IRQ(N)) bus ();

  irq_controller #(.N_IRQ(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: a handler is either absent, just entered (trap
  // cycle), running, or being acknowledged (ret mask nonzero).
  bit          m_busy   = 1'b0;
  bit          m_first  = 1'b0;
  logic [15:0] m_ret    = '0;
  int          m_cur    = 0;
  logic [31:0] m_mcause = '0;

  task automatic model_edge();
    logic [15:0] pend, iso;
    if (rst) begin
      m_busy = 0; m_first = 0; m_ret = '0; m_cur = 0; m_mcause = '0;
    end else if (m_ret != 0) begin
      m_ret = '0;
    end else if (m_busy) begin
      if (m_first) m_first = 0;
      else if (bus.mret_i) begin
        m_busy = 0;
        m_ret  = 16'(1) << m_cur;
      end
    end else begin
      pend = bus.irq_req_i & bus.mie_i[31:16];
      if (pend != 0 && bus.instr_boundary_i) begin
        iso      = pend & (~pend + 16'd1);
        m_cur    = $clog2(iso);
        m_mcause = 32'h8000_0010 + m_cur;
        m_busy   = 1; m_first = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("trap",   32'(bus.trap_o),    32'(m_busy && m_first));
    chk("busy",   32'(bus.busy_o),    32'(m_busy));
    chk("irqret", 32'(bus.irq_ret_o), 32'(m_ret));
    chk("mcause", bus.mcause_o,       m_mcause);
  endtask

  // From a visible TRAP cycle: enter SERVICE, pulse mret, drop requests
  // during RETURN, land in IDLE.
  task automatic finish_handler();
    step();
    bus.mret_i = 1; step();
    bus.mret_i = 0; bus.irq_req_i = '0; step();
  endtask

  initial begin
    bus.irq_req_i = 16'hFFFF;
    bus.mie_i = '1;
    bus.instr_boundary_i = 1;
    bus.mret_i = 0;

    // Reset values
    rst = 1; step(); chk("rst_trap", 32'(bus.trap_o), 0);
    step(); chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_mcause", bus.mcause_o, 0);
    rst = 0; step();
    chk("rel_trap", 32'(bus.trap_o), 1);
    chk("rel_mcause", bus.mcause_o, 32'h8000_0010);
    finish_handler();

    // Masking and priority
    bus.irq_req_i = 16'h0028; bus.mie_i = 32'h0020_0000; step();
    chk("mask_trap", 32'(bus.trap_o), 1);
    chk("mask_mcause", bus.mcause_o, 32'h8000_0015);
    bus.mie_i = '0; step();
    bus.irq_req_i = 16'h0028;
    bus.mret_i = 1; step(); bus.mret_i = 0; step();
    repeat (4) begin step(); chk("mask_notrap", 32'(bus.trap_o), 0); end
    bus.irq_req_i = '0;

    // Boundary wait with late higher-priority request
    bus.mie_i = 32'hFFFF_0000; bus.irq_req_i = 16'h0008; bus.instr_boundary_i = 0;
    repeat (5) begin step(); chk("wait_notrap", 32'(bus.trap_o), 0); end
    bus.instr_boundary_i = 1; bus.irq_req_i = 16'h000A; step();
    chk("wait_trap", 32'(bus.trap_o), 1);
    chk("wait_mcause", bus.mcause_o, 32'h8000_0011);
    bus.instr_boundary_i = 0; finish_handler();

    // Full round trip
    bus.instr_boundary_i = 1; bus.irq_req_i = 16'h0080; step();
    chk("rt_mcause7", bus.mcause_o, 32'h8000_0017);
    bus.irq_req_i = 16'h0084;
    repeat (11) begin step(); chk("rt_svc_notrap", 32'(bus.trap_o), 0); end
    bus.mret_i = 1; step(); bus.mret_i = 0;
    chk("rt_ret", 32'(bus.irq_ret_o), 32'h0080);
    step(); chk("rt_idle", 32'(bus.busy_o), 0);
    step();
    chk("rt_retrap", 32'(bus.trap_o), 1);
    chk("rt_mcause2", bus.mcause_o, 32'h8000_0012);
    finish_handler();

    // Spurious mret in IDLE
    bus.mret_i = 1; step(); bus.mret_i = 0;
    chk("spur_ret", 32'(bus.irq_ret_o), 0);
    step(); chk("spur_ret2", 32'(bus.irq_ret_o), 0);
    chk("spur_busy", 32'(bus.busy_o), 0);

    // Reset mid-service
    bus.irq_req_i = 16'h0010; step(); step();
    chk("rs_busy_svc", 32'(bus.busy_o), 1);
    rst = 1; step(); rst = 0;
    chk("rs_busy", 32'(bus.busy_o), 0);
    chk("rs_ret", 32'(bus.irq_ret_o), 0);
    step();
    chk("rs_retrap", 32'(bus.trap_o), 1);
    chk("rs_mcause", bus.mcause_o, 32'h8000_0014);
    finish_handler();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      bus.irq_req_i        = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'(1) << $urandom_range(0, 15);
      bus.mie_i            = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_0000;
      bus.instr_boundary_i = $urandom_range(0, 2) != 0;
      bus.mret_i           = ($urandom_range(0, 3) == 0) && !(m_busy && m_first);
      rst                  = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
